// File: rtl/otp_pkg.sv
// Shared types and defaults for the one-time-pad stream XOR engine.
package otp_pkg;

    localparam int unsigned DefDataW = 8;
    localparam int unsigned DefDepth = 4;
    localparam int unsigned DefCntW  = 16;

    typedef enum logic [0:0] {
        StWipe,
        StRun
    } otp_state_e;

    // Width able to hold 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/otp_pad_fifo.sv
// Pad FIFO: key words in, one word out per consume; consumed and wiped slots are zeroed.
module otp_pad_fifo
    import otp_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned DEPTH  = DefDepth
) (
    input  logic                          clk_i,
    input  logic                          reset_ni,
    input  logic                          clr_i,
    input  logic                          wr_en_i,
    input  logic [DATA_W-1:0]             wr_data_i,
    input  logic                          rd_en_i,
    output logic [DATA_W-1:0]             rd_data_o,
    input  logic                          wipe_en_i,
    input  logic [$clog2(DEPTH)-1:0]      wipe_idx_i,
    output logic [cnt_width(DEPTH)-1:0]   count_o
);

    localparam int unsigned PtrW   = $clog2(DEPTH);
    localparam int unsigned CountW = cnt_width(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CountW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        case ({wr_en_i, rd_en_i})
            2'b10:   count_d = count_q + CountW'(1);
            2'b01:   count_d = count_q - CountW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en_i) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (rd_en_i) rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q <= count_d;
        end
    end

    // Storage is deliberately not reset; the wipe sweep clears it.
    // Write and consume never target the same slot: that needs an empty or full FIFO.
    always_ff @(posedge clk_i) begin
        if (wipe_en_i) begin
            mem_q[wipe_idx_i] <= '0;
        end else begin
            if (rd_en_i) mem_q[rd_ptr_q] <= '0;
            if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;

endmodule

// File: rtl/otp_stream_cipher.sv
// One-time-pad XOR engine: each plaintext word consumes and destroys exactly one pad word.
module otp_stream_cipher
    import otp_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned DEPTH  = DefDepth,
    parameter int unsigned CNT_W  = DefCntW
) (
    input  logic                        clk_i,
    input  logic                        reset_ni,
    input  logic                        key_valid_i,
    input  logic [DATA_W-1:0]           key_data_i,
    output logic                        key_ready_o,
    input  logic                        pt_valid_i,
    input  logic [DATA_W-1:0]           pt_data_i,
    output logic                        pt_ready_o,
    output logic                        ct_valid_o,
    output logic [DATA_W-1:0]           ct_data_o,
    input  logic                        ct_ready_i,
    input  logic                        zeroize_i,
    output logic                        wipe_busy_o,
    output logic [cnt_width(DEPTH)-1:0] key_count_o,
    output logic [CNT_W-1:0]            keys_used_o,
    output logic                        starve_o
);

    localparam int unsigned PtrW   = $clog2(DEPTH);
    localparam int unsigned CountW = cnt_width(DEPTH);

    otp_state_e        state_q, state_d;
    logic [PtrW-1:0]   wipe_idx_q, wipe_idx_d;
    logic              ct_valid_q, ct_valid_d;
    logic [DATA_W-1:0] ct_data_q, ct_data_d;
    logic [CNT_W-1:0]  keys_used_q, keys_used_d;
    logic              starve_q, starve_d;

    logic              wipe_en, clr;
    logic              key_fire, pt_fire;
    logic [DATA_W-1:0] pad_word;
    logic [CountW-1:0] count;
    logic              in_run;

    otp_pad_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk_i      (clk_i),
        .reset_ni   (reset_ni),
        .clr_i      (clr),
        .wr_en_i    (key_fire),
        .wr_data_i  (key_data_i),
        .rd_en_i    (pt_fire),
        .rd_data_o  (pad_word),
        .wipe_en_i  (wipe_en),
        .wipe_idx_i (wipe_idx_q),
        .count_o    (count)
    );

    assign in_run      = (state_q == StRun);
    assign key_ready_o = in_run && (count != CountW'(DEPTH)) && !zeroize_i;
    assign pt_ready_o  = in_run && (count != '0) && (!ct_valid_q || ct_ready_i) && !zeroize_i;
    assign key_fire    = key_valid_i && key_ready_o;
    assign pt_fire     = pt_valid_i && pt_ready_o;

    always_comb begin
        state_d    = state_q;
        wipe_idx_d = wipe_idx_q;
        wipe_en    = 1'b0;
        clr        = 1'b0;
        unique case (state_q)
            StWipe: begin
                wipe_en = 1'b1;
                if (zeroize_i) begin
                    wipe_idx_d = '0;
                    clr        = 1'b1;
                end else if (wipe_idx_q == PtrW'(DEPTH - 1)) begin
                    wipe_idx_d = '0;
                    state_d    = StRun;
                end else begin
                    wipe_idx_d = wipe_idx_q + PtrW'(1);
                end
            end
            StRun: begin
                if (zeroize_i) begin
                    wipe_idx_d = '0;
                    clr        = 1'b1;
                    state_d    = StWipe;
                end
            end
            default: state_d = StWipe;
        endcase
    end

    always_comb begin
        ct_valid_d  = ct_valid_q;
        ct_data_d   = ct_data_q;
        keys_used_d = keys_used_q;
        starve_d    = starve_q;
        if (clr) begin
            ct_valid_d = 1'b0;
            ct_data_d  = '0;
        end else if (pt_fire) begin
            ct_valid_d = 1'b1;
            ct_data_d  = pt_data_i ^ pad_word;
        end else if (ct_valid_q && ct_ready_i) begin
            ct_valid_d = 1'b0;
            ct_data_d  = '0;
        end
        if (pt_fire && (keys_used_q != {CNT_W{1'b1}})) begin
            keys_used_d = keys_used_q + CNT_W'(1);
        end
        if (in_run && pt_valid_i && (count == '0)) begin
            starve_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= StWipe;
            wipe_idx_q  <= '0;
            ct_valid_q  <= 1'b0;
            ct_data_q   <= '0;
            keys_used_q <= '0;
            starve_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            wipe_idx_q  <= wipe_idx_d;
            ct_valid_q  <= ct_valid_d;
            ct_data_q   <= ct_data_d;
            keys_used_q <= keys_used_d;
            starve_q    <= starve_d;
        end
    end

    assign ct_valid_o  = ct_valid_q;
    assign ct_data_o   = ct_data_q;
    assign wipe_busy_o = (state_q == StWipe);
    assign key_count_o = count;
    assign keys_used_o = keys_used_q;
    assign starve_o    = starve_q;

endmodule

// File: doc/otp_stream_cipher.md
Name: otp_stream_cipher

Overview:
- Parametrised one-time-pad stream XOR engine; successor to the single static-key XOR block.
- Key words are loaded into a pad FIFO, and each plaintext word consumes exactly one pad word, so a pad word is never reused.
- Each pad entry is overwritten with zero as it is consumed; zeroize and reset trigger a full sequential wipe.
- Sits between the key provisioning port and the data path under side-channel evaluation; encrypt and decrypt are the same operation.

Parameters:
- DATA_W, 8, width of key, plaintext and ciphertext words.
- DEPTH, 4, pad FIFO entries (power of two, >=2).
- CNT_W, 16, width of the consumed-key counter.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- key_valid  in  1  key word offered.
- key_data  in  DATA_W  key word.
- key_ready  out  1  pad FIFO accepts a key word.
- pt_valid  in  1  plaintext word offered.
- pt_data  in  DATA_W  plaintext word.
- pt_ready  out  1  plaintext accepted this cycle.
- ct_valid  out  1  ciphertext register holds a result.
- ct_data  out  DATA_W  ciphertext word.
- ct_ready  in  1  downstream accepts ciphertext.
- zeroize  in  1  single-cycle pulse requesting a pad wipe.
- wipe_busy  out  1  wipe in progress.
- key_count  out  $clog2(DEPTH+1)  unconsumed pad words.
- keys_used  out  CNT_W  total pad words consumed; saturates at all-ones.
- starve  out  1  sticky flag: pt_valid was high while key_count==0 outside a wipe.

Behaviour:
- Reset (async assert, sync release):
  - wr_ptr, rd_ptr, key_count, keys_used, ct_valid, ct_data and starve all go to 0.
  - The state machine goes to WIPE with wipe_idx=0. The pad memory itself is not reset; the WIPE sweep clears it.
- States:
  - WIPE:
    - Each cycle, mem[wipe_idx]<=0 and wipe_idx++.
    - After the DEPTH-th write, go to RUN.
    - wipe_busy=1 in WIPE. key_ready=0 and pt_ready=0.
  - RUN: normal operation.
  - RUN -> WIPE on zeroize=1. On entry, wr_ptr, rd_ptr, key_count, ct_valid and ct_data go to 0. keys_used and starve are held.
  - A zeroize pulse during WIPE restarts the sweep at wipe_idx=0.
- Key load (RUN):
  - key_ready = (key_count!=DEPTH) && !zeroize.
  - On key_valid&&key_ready: mem[wr_ptr]<=key_data, wr_ptr++ (wraps mod DEPTH).
- Consume (RUN):
  - pt_ready = (key_count!=0) && (!ct_valid || ct_ready) && !zeroize.
  - On pt_valid&&pt_ready, all of the following happen in the same edge:
    - ct_data <= pt_data ^ mem[rd_ptr], ct_valid<=1.
    - mem[rd_ptr]<=0.
    - rd_ptr++ (wraps).
    - keys_used++ (saturating).
- Latency:
  - Plaintext to ciphertext is 1 cycle.
  - Key write to usability is 1 cycle; there is no same-cycle bypass when the FIFO is empty.
- Output:
  - On ct_valid&&ct_ready with no new consume in the same cycle, ct_valid<=0 and ct_data<=0. ct_data is 0 whenever ct_valid=0.
  - Full throughput: back-to-back words while ct_ready=1 and pad words are available.
- Simultaneous load and consume: key_count is unchanged and both pointers advance. If wr_ptr==rd_ptr, the read uses the old entry; the write goes to the freed slot only if the FIFO is not full. The full-FIFO case cannot occur because key_ready=0 when full.
- Counter rule: key_count = key_count + load - consume. It never exceeds DEPTH and never underflows.
- starve: set in RUN when pt_valid && key_count==0. Cleared only by reset.
- Zeroize has priority over a load or consume in the same cycle; neither handshake fires.

Decomposition:
- Package otp_pkg holds:
  - the state enum {ST_WIPE, ST_RUN};
  - a helper for the count width;
  - the default parameter constants.
- Sub-module otp_pad_fifo holds:
  - the memory, pointers and key_count;
  - ports for write, consume-with-zero and wipe-index write.
- The top level holds the state machine, XOR, output register, keys_used and starve.

Test Plan:
- Reset release -> wipe_busy=1 for exactly 4 cycles, then key_ready=1; key_count=0 and ct_data=0 throughout.
- Load keys 0xA5,0x3C,0xFF,0x01 and send pt 0x5A,0x3C,0x00,0x10 with ct_ready=1 -> ct 0xFF,0x00,0xFF,0x11 on consecutive cycles; keys_used=4, key_count=0.
- Load 4 keys and assert key_valid for a 5th -> key_ready=0, key_count=4. Then send pt with ct_ready=0 -> one ct held, pt_ready=0 until ct_ready=1.
- Send pt 0x77 with key_count=0 -> pt_ready=0, starve=1 (sticky). Load key 0x11 -> next cycle pt accepted, ct=0x66.
- Load 3 keys, consume 1, pulse zeroize together with key_valid and pt_valid -> neither handshake fires; wipe_busy=1 for 4 cycles; key_count=0; ct_valid=0; keys_used stays 1.
- Wrap-around: load/consume 10 words interleaved through DEPTH=4 -> every ct equals pt^key in order; a backdoor read of each consumed slot returns 0.
